// File: rtl/smac_pkg.sv
// Shared types and token-pipe offsets for the bit-serial MAC control sequencer.
package smac_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      OUT   = 2'd3
   } smac_state_t;

   // Per-accept control token: first/last flags of each loop level plus channel index.
   typedef struct packed {
      logic       fa;
      logic       la;
      logic       fw;
      logic       lw;
      logic [1:0] k;
      logic       fg;
      logic       lg;
   } smac_tok_t;

   localparam int unsigned OFS_BR  = 1;
   localparam int unsigned OFS_AC1 = 2;
   localparam int unsigned OFS_NEG = 3;
   localparam int unsigned OFS_AC2 = 4;
   localparam int unsigned OFS_AC3 = 5;

endpackage

// File: rtl/ctrl_token_pipe.sv
// Fixed-depth valid+token delay line; stage n holds the token accepted n+1 cycles ago.
module ctrl_token_pipe
   import smac_pkg::*;
#(
   parameter int unsigned DEPTH = OFS_AC3
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    push_i,
   input  smac_tok_t               tok_i,
   output logic [DEPTH-1:0]        vld_o,
   output smac_tok_t [DEPTH-1:0]   tok_o
);

   logic [DEPTH-1:0]      vld_q;
   smac_tok_t [DEPTH-1:0] tok_q;

   // Cycles without a push shift a bubble in, keeping later strobes aligned to their accepts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         tok_q <= '0;
      end else begin
         vld_q <= {vld_q[DEPTH-2:0], push_i};
         tok_q <= {tok_q[DEPTH-2:0], tok_i};
      end
   end

   assign vld_o = vld_q;
   assign tok_o = tok_q;

endmodule

// File: rtl/smac_ctrl.sv
// Control sequencer for the bit-serial MAC datapath: loop-nest counters, token-delayed
// strobes for batches 0-3, and the 4-cycle quantize/ReLU readout.
module smac_ctrl
   import smac_pkg::*;
#(
   parameter int unsigned Pa = 8,
   parameter int unsigned Pw = 4,
   parameter int unsigned GW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [GW-1:0] n_groups,
   input  logic          in_valid,
   output logic          in_ready,
   output logic          cl_en_gen,
   output logic          w_en_w,
   output logic          w_en_a,
   output logic          w_en_br,
   output logic          MSB_a,
   output logic          w_and_s_ac1,
   output logic          cl_en_ac1,
   output logic          MSB_w,
   output logic          w_en_neg,
   output logic          valid_ac2,
   output logic          cl_en_ac2,
   output logic [1:0]    sel_ac2,
   output logic          valid_ac3,
   output logic          cl_en_ac3,
   output logic          s_en_ac3,
   output logic [1:0]    sel_ac3,
   output logic [1:0]    sel_mux_relu,
   output logic          out_valid,
   output logic          busy,
   output logic          done
);

   localparam int unsigned IW     = $clog2(Pa);
   localparam int unsigned JW     = $clog2(Pw);
   localparam int unsigned DEPTH  = OFS_AC3;
   localparam int unsigned S_BR   = OFS_BR - 1;
   localparam int unsigned S_AC1  = OFS_AC1 - 1;
   localparam int unsigned S_NEG  = OFS_NEG - 1;
   localparam int unsigned S_AC2  = OFS_AC2 - 1;
   localparam int unsigned S_AC3  = OFS_AC3 - 1;
   localparam logic [IW-1:0] I_TOP = IW'(Pa - 1);
   localparam logic [JW-1:0] J_TOP = JW'(Pw - 1);

   smac_state_t   state_q, state_d;
   logic [IW-1:0] i_q, i_d;
   logic [JW-1:0] j_q, j_d;
   logic [1:0]    k_q, k_d;
   logic [GW-1:0] g_q, g_d;
   logic [GW-1:0] ng_q, ng_d;
   logic [1:0]    ocnt_q, ocnt_d;
   logic          gen_q, gen_d;

   logic                  accept;
   logic                  last_grp;
   logic                  last_plane;
   smac_tok_t             push_tok;
   logic [DEPTH-1:0]      pv;
   smac_tok_t [DEPTH-1:0] pt;
   logic                  unused_tok;

   assign accept     = (state_q == RUN) && in_valid;
   assign last_grp   = (g_q == ng_q - GW'(1));
   assign last_plane = (i_q == '0) && (j_q == '0) && (k_q == 2'd3) && last_grp;

   assign push_tok = '{fa: (i_q == I_TOP), la: (i_q == '0),
                       fw: (j_q == J_TOP), lw: (j_q == '0),
                       k:  k_q,
                       fg: (g_q == '0),    lg: last_grp};

   // Next-state: FSM plus the i (inner) -> j -> k -> g (outer) loop nest.
   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      j_d     = j_q;
      k_d     = k_q;
      g_d     = g_q;
      ng_d    = ng_q;
      ocnt_d  = ocnt_q;
      gen_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               ng_d    = (n_groups == '0) ? GW'(1) : n_groups;
               i_d     = I_TOP;
               j_d     = J_TOP;
               k_d     = '0;
               g_d     = '0;
               gen_d   = 1'b1;
            end
         end
         RUN: begin
            if (accept) begin
               if (i_q == '0) begin
                  i_d = I_TOP;
                  if (j_q == '0) begin
                     j_d = J_TOP;
                     k_d = k_q + 2'd1;
                     if (k_q == 2'd3) g_d = g_q + GW'(1);
                  end else begin
                     j_d = j_q - JW'(1);
                  end
               end else begin
                  i_d = i_q - IW'(1);
               end
               if (last_plane) state_d = DRAIN;
            end
         end
         DRAIN: begin
            // Only the oldest stage may still be occupied; it leaves on this edge.
            if (pv[DEPTH-2:0] == '0) begin
               state_d = OUT;
               ocnt_d  = '0;
            end
         end
         OUT: begin
            ocnt_d = ocnt_q + 2'd1;
            if (ocnt_q == 2'd3) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         i_q     <= '0;
         j_q     <= '0;
         k_q     <= '0;
         g_q     <= '0;
         ng_q    <= '0;
         ocnt_q  <= '0;
         gen_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         j_q     <= j_d;
         k_q     <= k_d;
         g_q     <= g_d;
         ng_q    <= ng_d;
         ocnt_q  <= ocnt_d;
         gen_q   <= gen_d;
      end
   end

   ctrl_token_pipe #(.DEPTH(DEPTH)) u_pipe (
      .clk    (clk),
      .rst_n  (rst_n),
      .push_i (accept),
      .tok_i  (push_tok),
      .vld_o  (pv),
      .tok_o  (pt)
   );

   assign unused_tok = ^pt;

   assign in_ready  = (state_q == RUN);
   assign busy      = (state_q != IDLE);
   assign cl_en_gen = gen_q;
   assign w_en_a    = accept;
   assign w_en_w    = accept && (i_q == I_TOP);

   // Strobe decode: every field is gated by its stage valid so bubbles read as 0.
   assign w_en_br     = pv[S_BR];
   assign MSB_a       = pv[S_BR] && pt[S_BR].fa;
   assign w_and_s_ac1 = pv[S_AC1];
   assign cl_en_ac1   = pv[S_AC1] && pt[S_AC1].fa;
   assign w_en_neg    = pv[S_NEG] && pt[S_NEG].la;
   assign MSB_w       = w_en_neg && pt[S_NEG].fw;
   assign valid_ac2   = pv[S_AC2] && pt[S_AC2].la;
   assign sel_ac2     = valid_ac2 ? pt[S_AC2].k : 2'b00;
   assign cl_en_ac2   = valid_ac2 && pt[S_AC2].fw;
   assign valid_ac3   = pv[S_AC3] && pt[S_AC3].la && pt[S_AC3].lw;
   assign sel_ac3     = valid_ac3 ? pt[S_AC3].k : 2'b00;
   assign cl_en_ac3   = valid_ac3 && pt[S_AC3].fg;
   assign s_en_ac3    = valid_ac3 && pt[S_AC3].lg;

   assign out_valid    = (state_q == OUT);
   assign sel_mux_relu = out_valid ? ocnt_q : 2'b00;
   assign done         = out_valid && (ocnt_q == 2'd3);

endmodule

// File: tb/tb_smac_ctrl.sv
// Directed bench for smac_ctrl: hand-computed pulse counts, ac3/readout sequences,
// job latency, and a per-cycle offset model of the token-driven strobes.
module tb_smac_ctrl;

   localparam int PA = 8;
   localparam int PW = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] n_groups = 8'd0;
   logic       in_valid = 1'b0;
   logic       in_ready, cl_en_gen, w_en_w, w_en_a, w_en_br, MSB_a;
   logic       w_and_s_ac1, cl_en_ac1, MSB_w, w_en_neg;
   logic       valid_ac2, cl_en_ac2, valid_ac3, cl_en_ac3, s_en_ac3;
   logic [1:0] sel_ac2, sel_ac3, sel_mux_relu;
   logic       out_valid, busy, done;

   smac_ctrl dut (
      .clk(clk), .rst_n(rst_n), .start(start), .n_groups(n_groups),
      .in_valid(in_valid), .in_ready(in_ready), .cl_en_gen(cl_en_gen),
      .w_en_w(w_en_w), .w_en_a(w_en_a), .w_en_br(w_en_br), .MSB_a(MSB_a),
      .w_and_s_ac1(w_and_s_ac1), .cl_en_ac1(cl_en_ac1), .MSB_w(MSB_w),
      .w_en_neg(w_en_neg), .valid_ac2(valid_ac2), .cl_en_ac2(cl_en_ac2),
      .sel_ac2(sel_ac2), .valid_ac3(valid_ac3), .cl_en_ac3(cl_en_ac3),
      .s_en_ac3(s_en_ac3), .sel_ac3(sel_ac3), .sel_mux_relu(sel_mux_relu),
      .out_valid(out_valid), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   wire [24:0] all_out = {in_ready, cl_en_gen, w_en_w, w_en_a, w_en_br, MSB_a,
                          w_and_s_ac1, cl_en_ac1, MSB_w, w_en_neg, valid_ac2,
                          cl_en_ac2, sel_ac2, valid_ac3, cl_en_ac3, s_en_ac3,
                          sel_ac3, sel_mux_relu, out_valid, busy, done};

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   // Per-job observations and the loop-nest reference model.
   int cnt_wa, cnt_ww, cnt_ac2, cnt_ac3, cnt_msba, cnt_msbw, cnt_out, cnt_gen;
   int gen_cyc, done_cyc, first_acc, align_err;
   logic [31:0] ac3_log;
   logic [7:0]  sel_log;
   int mi, mj, mk, mg, mng;
   bit in_job = 0;
   logic [14:0] ring [8];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Sample mid-cycle; compare strobes against what earlier accepts scheduled for this cycle.
   always @(negedge clk) begin
      logic [14:0] obs;
      logic acc, fa, la, fw, lw, fg, lg;
      if (!rst_n) begin
         for (int n = 0; n < 8; n++) ring[n] = '0;
         in_job = 0;
      end else begin
         if (start && !in_job) begin
            cnt_wa = 0; cnt_ww = 0; cnt_ac2 = 0; cnt_ac3 = 0; cnt_msba = 0;
            cnt_msbw = 0; cnt_out = 0; cnt_gen = 0; gen_cyc = -1; done_cyc = -1;
            first_acc = -1; align_err = 0; ac3_log = '0; sel_log = '0;
            mng = (n_groups == 8'd0) ? 1 : int'(n_groups);
            mi = PA - 1; mj = PW - 1; mk = 0; mg = 0;
            in_job = 1;
         end
         obs = {w_en_br, MSB_a, w_and_s_ac1, cl_en_ac1, w_en_neg, MSB_w,
                valid_ac2, sel_ac2, cl_en_ac2, valid_ac3, sel_ac3, cl_en_ac3, s_en_ac3};
         if (obs !== ring[cyc % 8]) align_err++;
         ring[cyc % 8] = '0;
         acc = in_valid && in_ready;
         if (w_en_a !== acc) align_err++;
         if (w_en_w !== (acc && mi == PA - 1)) align_err++;
         if (acc) begin
            if (first_acc < 0) first_acc = cyc;
            fa = (mi == PA - 1); la = (mi == 0);
            fw = (mj == PW - 1); lw = (mj == 0);
            fg = (mg == 0);      lg = (mg == mng - 1);
            ring[(cyc + 1) % 8] |= {1'b1, fa, 13'b0};
            ring[(cyc + 2) % 8] |= {2'b0, 1'b1, fa, 11'b0};
            if (la) begin
               ring[(cyc + 3) % 8] |= {4'b0, 1'b1, fw, 9'b0};
               ring[(cyc + 4) % 8] |= {6'b0, 1'b1, 2'(mk), fw, 5'b0};
            end
            if (la && lw) ring[(cyc + 5) % 8] |= {10'b0, 1'b1, 2'(mk), fg, lg};
            if (mi == 0) begin
               mi = PA - 1;
               if (mj == 0) begin
                  mj = PW - 1;
                  mk = (mk + 1) % 4;
                  if (mk == 0) mg++;
               end else mj--;
            end else mi--;
         end
         if (w_en_a) cnt_wa++;
         if (w_en_w) cnt_ww++;
         if (valid_ac2) cnt_ac2++;
         if (MSB_a) cnt_msba++;
         if (MSB_w) cnt_msbw++;
         if (cl_en_gen) begin cnt_gen++; gen_cyc = cyc; end
         if (valid_ac3) begin
            cnt_ac3++;
            ac3_log = {ac3_log[27:0], cl_en_ac3, s_en_ac3, sel_ac3};
         end
         if (out_valid) begin cnt_out++; sel_log = {sel_log[5:0], sel_mux_relu}; end
         if (done) begin done_cyc = cyc; in_job = 0; end
      end
   end

   task automatic run_job(input logic [7:0] ng, input int eff, input int stall_at,
                          input int stall_len, input logic [31:0] exp_log, input string nm);
      int run_cyc;
      bit stalled, sp_run, sp_out;
      stalled = 0; sp_run = 0; sp_out = 0;
      @(posedge clk); #1;
      start = 1'b1; n_groups = ng; in_valid = 1'b1;
      @(posedge clk); #1;
      run_cyc = cyc;
      start = 1'b0;
      n_groups = 8'd3;
      for (int t = 0; t < 3000 && done_cyc < 0; t++) begin
         @(posedge clk); #1;
         start = 1'b0;
         if (!stalled && stall_len > 0 && cnt_wa == stall_at) begin
            in_valid = 1'b0;
            stalled = 1;
            repeat (stall_len) @(posedge clk);
            #1 in_valid = 1'b1;
         end
         if (!sp_run && cnt_wa == 50) begin start = 1'b1; sp_run = 1; end
         if (!sp_out && cnt_out >= 1) begin start = 1'b1; sp_out = 1; end
      end
      start = 1'b0;
      in_valid = 1'b0;
      chk({nm, ":done_seen"}, 32'(done_cyc >= 0), 32'd1);
      chk({nm, ":done_lat"}, 32'(done_cyc - run_cyc), 32'(128 * eff + 8 + stall_len));
      chk({nm, ":first_acc"}, 32'(first_acc - run_cyc), 32'd0);
      chk({nm, ":gen"}, 32'({cnt_gen[7:0], 8'(gen_cyc - run_cyc)}), 32'h0100);
      chk({nm, ":w_en_a"}, 32'(cnt_wa), 32'(128 * eff));
      chk({nm, ":w_en_w"}, 32'(cnt_ww), 32'(16 * eff));
      chk({nm, ":valid_ac2"}, 32'(cnt_ac2), 32'(16 * eff));
      chk({nm, ":valid_ac3"}, 32'(cnt_ac3), 32'(4 * eff));
      chk({nm, ":MSB_a"}, 32'(cnt_msba), 32'(16 * eff));
      chk({nm, ":MSB_w"}, 32'(cnt_msbw), 32'(4 * eff));
      chk({nm, ":ac3_seq"}, ac3_log, exp_log);
      chk({nm, ":out_cnt"}, 32'(cnt_out), 32'd4);
      chk({nm, ":relu_sel"}, 32'(sel_log), 32'h1B);
      chk({nm, ":align"}, 32'(align_err), 32'd0);
      repeat (2) @(negedge clk);
      chk({nm, ":idle_after"}, 32'({busy, in_ready, out_valid}), 32'd0);
   endtask

   initial begin
      #1;
      chk("reset_outs", 32'(all_out), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      run_job(8'd1, 1, -1, 0, 32'h0000CDEF, "ng1");
      run_job(8'd2, 2, -1, 0, 32'h89AB4567, "ng2");
      run_job(8'd1, 1, 3, 3, 32'h0000CDEF, "stall3");

      // Abort a job at g=0, k=2 (accept 72) with an asynchronous reset.
      @(posedge clk); #1;
      start = 1'b1; n_groups = 8'd1; in_valid = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int t = 0; t < 500 && cnt_wa < 72; t++) begin
         @(posedge clk); #1;
      end
      chk("abort_reached", 32'(cnt_wa >= 72), 32'd1);
      rst_n = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("abort_outs", 32'(all_out), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      run_job(8'd1, 1, -1, 0, 32'h0000CDEF, "after_rst");
      run_job(8'd0, 1, -1, 0, 32'h0000CDEF, "ng0");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
